gray_conv_arbiter: RTL and testbench

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

---
 rtl/gray_conv_arbiter.sv | 126 ++++++++++++
 tb/tb_gray_conv_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Two-requester round-robin arbiter that accepts one Gray-coded word at a
//   time and converts it to binary serially, one bit per clock, MSB first.
//   The result is held on Out until the consumer accepts it.
//
// Ports
//   Clk        : clock, rising-edge active
//   Rst_n      : asynchronous active-low reset
//   In0/In1    : Gray-coded request words, WIDTH bits
//   InX_valid  : request word valid
//   InX_ready  : request word accepted this cycle
//   Out        : binary result, WIDTH bits
//   Out_id     : index of the requester that owns Out
//   Out_valid  : Out/Out_id valid
//   Out_ready  : consumer accepts Out
//   Busy       : high whenever the FSM is not idle
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational
// CONV  | resolving one binary bit per clock, MSB first
// HOLD  | result presented, waiting for Out_ready
module gray_conv_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In0,
  input  logic             In0_valid,
  output logic             In0_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic             In1_valid,
  output logic             In1_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_id,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic             Busy
);

  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_out;
  logic [IDXW-1:0]  r_idx;
  logic             r_bprev;
  logic             r_id_pend;
  logic             r_out_id;
  logic             r_out_valid;
  logic             r_last;

  logic             w_grant;
  logic             w_accept;
  logic             w_bit;
  logic [WIDTH-1:0] w_final;

  // On contention the requester that was not served last wins.
  assign w_grant  = (In0_valid && In1_valid) ? ~r_last : In1_valid;
  // Rst_n gates the ready outputs so they stay low for the whole reset.
  assign w_accept = Rst_n && (r_state == IDLE) && (In0_valid || In1_valid);

  assign In0_ready = w_accept && !w_grant;
  assign In1_ready = w_accept &&  w_grant;

  // r_bprev carries b[i+1]; it is cleared on accept so b[WIDTH] = 0.
  assign w_bit   = r_gray[r_idx] ^ r_bprev;
  assign w_final = {r_work[WIDTH-1:1], w_bit};

  assign Out       = r_out;
  assign Out_id    = r_out_id;
  assign Out_valid = r_out_valid;
  assign Busy      = (r_state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_gray      <= '0;
      r_work      <= '0;
      r_out       <= '0;
      r_idx       <= '0;
      r_bprev     <= 1'b0;
      r_id_pend   <= 1'b0;
      r_out_id    <= 1'b0;
      r_out_valid <= 1'b0;
      // Pretend requester 1 was served last so requester 0 wins first.
      r_last      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_gray    <= w_grant ? In1 : In0;
            r_id_pend <= w_grant;
            r_last    <= w_grant;
            r_idx     <= IDXW'(WIDTH-1);
            r_bprev   <= 1'b0;
            r_work    <= '0;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_work[r_idx] <= w_bit;
          r_bprev       <= w_bit;
          if (r_idx == '0) begin
            r_out       <= w_final;
            r_out_id    <= r_id_pend;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        HOLD: begin
          if (Out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic [W-1:0] In0 = '0;
  logic [W-1:0] In1 = '0;
  logic         In0_valid = 1'b0;
  logic         In1_valid = 1'b0;
  logic         Out_ready = 1'b0;
  logic         In0_ready;
  logic         In1_ready;
  logic [W-1:0] Out;
  logic         Out_id;
  logic         Out_valid;
  logic         Busy;

  int n_checks = 0;
  int n_fail   = 0;

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In0       (In0),
    .In0_valid (In0_valid),
    .In0_ready (In0_ready),
    .In1       (In1),
    .In1_valid (In1_valid),
    .In1_ready (In1_ready),
    .Out       (Out),
    .Out_id    (Out_id),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Transaction-level model: phase 0 idle, 1 converting, 2 holding.
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [W-1:0] m_gray  = '0;
  logic [W-1:0] m_out   = '0;
  logic         m_idp   = 1'b0;
  logic         m_id    = 1'b0;
  logic         m_last  = 1'b1;
  logic         m_g;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_phase = 0; m_cnt = 0; m_gray = '0; m_out = '0;
      m_idp = 1'b0; m_id = 1'b0; m_last = 1'b1;
    end else begin
      case (m_phase)
        0: if (In0_valid || In1_valid) begin
             m_g = (In0_valid && In1_valid) ? ~m_last : In1_valid;
             m_gray = m_g ? In1 : In0;
             m_idp = m_g; m_last = m_g;
             m_cnt = W; m_phase = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) begin
               m_out = g2b(m_gray); m_id = m_idp; m_phase = 2;
             end
           end
        default: if (Out_ready) m_phase = 0;
      endcase
    end
  end

  logic e_g, e_r0, e_r1;
  always @(negedge Clk) begin
    e_g  = (In0_valid && In1_valid) ? ~m_last : In1_valid;
    e_r0 = Rst_n && (m_phase == 0) && (In0_valid || In1_valid) && !e_g;
    e_r1 = Rst_n && (m_phase == 0) && (In0_valid || In1_valid) &&  e_g;
    chk("cmp_in0_ready", In0_ready, e_r0);
    chk("cmp_in1_ready", In1_ready, e_r1);
    chk("cmp_ready_excl", In0_ready && In1_ready, 0);
    chk("cmp_out_valid", Out_valid, m_phase == 2);
    chk("cmp_busy", Busy, m_phase != 0);
    chk("cmp_out", Out, m_out);
    chk("cmp_out_id", Out_id, m_id);
  end

  task automatic tick;
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!Out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    Rst_n = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  int  n;
  logic acc0, acc1;

  initial begin
    // Reset with toggling inputs
    Rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      In0 = W'($urandom); In1 = W'($urandom);
      In0_valid = ~In0_valid; In1_valid = (i % 3) == 0;
      Out_ready = i[0];
      tick();
      chk("rst_out", Out, 0);
      chk("rst_out_valid", Out_valid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_ready", {In0_ready, In1_ready}, 0);
    end
    In0_valid = 1'b0; In1_valid = 1'b0; Out_ready = 1'b0;
    tick();
    Rst_n = 1'b1;

    // Single request
    In0 = 8'hD6; In0_valid = 1'b1; Out_ready = 1'b1;
    #1 chk("single_ready0", In0_ready, 1);
    tick();
    In0_valid = 1'b0;
    wait_valid(n);
    chk("single_latency", n, 8);
    chk("single_out", Out, 8'h9B);
    chk("single_model", m_out, 8'h9B);
    chk("single_id", Out_id, 0);
    tick();
    chk("single_valid_1cyc", Out_valid, 0);

    // Contention after reset
    do_reset();
    In0 = 8'h00; In1 = 8'h80; In0_valid = 1'b1; In1_valid = 1'b1;
    #1 chk("cont_grant0", {In0_ready, In1_ready}, 2'b10);
    tick();
    In0_valid = 1'b0;
    wait_valid(n);
    chk("cont_lat0", n, 8);
    chk("cont_out0", Out, 8'h00);
    chk("cont_id0", Out_id, 0);
    tick();
    #1 chk("cont_grant1", In1_ready, 1);
    tick();
    In1_valid = 1'b0;
    wait_valid(n);
    chk("cont_out1", Out, 8'hFF);
    chk("cont_model1", m_out, 8'hFF);
    chk("cont_id1", Out_id, 1);
    tick();
    In0 = 8'h01; In1 = 8'h02; In0_valid = 1'b1; In1_valid = 1'b1;
    #1 chk("cont_rr_grant0", {In0_ready, In1_ready}, 2'b10);
    tick();
    In0_valid = 1'b0; In1_valid = 1'b0;
    wait_valid(n);
    chk("cont_out2", Out, 8'h01);
    chk("cont_id2", Out_id, 0);
    tick();

    // Backpressure
    Out_ready = 1'b0;
    In1 = 8'hFF; In1_valid = 1'b1;
    tick();
    In1_valid = 1'b0;
    In0 = 8'h55; In0_valid = 1'b1;
    wait_valid(n);
    chk("bp_out", Out, 8'hAA);
    chk("bp_id", Out_id, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out", Out, 8'hAA);
      chk("bp_hold_valid", Out_valid, 1);
      chk("bp_hold_busy", Busy, 1);
      chk("bp_hold_ready", {In0_ready, In1_ready}, 0);
    end
    Out_ready = 1'b1;
    tick();
    chk("bp_bubble_valid", Out_valid, 0);
    chk("bp_bubble_busy", Busy, 0);
    chk("bp_bubble_ready0", In0_ready, 1);
    tick();
    In0_valid = 1'b0;
    chk("bp_accept_busy", Busy, 1);
    chk("bp_accept_ready0", In0_ready, 0);
    wait_valid(n);
    chk("bp_out2", Out, 8'h66);
    chk("bp_id2", Out_id, 0);
    tick();

    // Reset mid-CONV
    In1 = 8'h3C; In1_valid = 1'b1;
    tick();
    In1_valid = 1'b0;
    repeat (3) tick();
    Rst_n = 1'b0;
    #1;
    chk("rmid_out", Out, 0);
    chk("rmid_id", Out_id, 0);
    chk("rmid_valid", Out_valid, 0);
    chk("rmid_busy", Busy, 0);
    chk("rmid_ready", {In0_ready, In1_ready}, 0);
    tick();
    tick();
    Rst_n = 1'b1;
    In0 = 8'h12; In1 = 8'h34; In0_valid = 1'b1; In1_valid = 1'b1;
    #1 chk("rmid_grant0", {In0_ready, In1_ready}, 2'b10);
    tick();
    In0_valid = 1'b0; In1_valid = 1'b0;
    wait_valid(n);
    chk("rmid_out2", Out, 8'h1C);
    chk("rmid_id2", Out_id, 0);
    tick();

    // Random valid/ready traffic, requesters hold until accepted
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!In0_valid || acc0) begin
        In0_valid = ($urandom_range(0, 1) == 1);
        In0 = W'($urandom);
      end
      if (!In1_valid || acc1) begin
        In1_valid = ($urandom_range(0, 1) == 1);
        In1 = W'($urandom);
      end
      Out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc0 = In0_valid && In0_ready;
      acc1 = In1_valid && In1_ready;
      tick();
    end
    In0_valid = 1'b0; In1_valid = 1'b0; Out_ready = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
